fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl_if.sv | 36 +++
 rtl/fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl_if : write-side bus of an asynchronous FIFO.
//   master : producer/testbench side (drives wr_req, rd_ptr_gray)
//   slave  : fifo_wr_ctrl side (drives strobe, address, pointer and flags)
// Signals:
//   wr_req       producer write request, one entry per cycle
//   rd_ptr_gray  read pointer (Gray) from the read clock domain
//   wr_en        memory write strobe
//   wr_addr      memory write address
//   wr_ptr_gray  registered Gray write pointer to the read domain
//   full         registered full flag
//   wr_count     registered write-side fill level
//   almost_full  registered almost-full flag
// ---------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  wr_req;
   logic [ADDR_WIDTH:0]   rd_ptr_gray;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH:0]   wr_ptr_gray;
   logic                  full;
   logic [ADDR_WIDTH:0]   wr_count;
   logic                  almost_full;

   modport master (
      output wr_req, rd_ptr_gray,
      input  wr_en, wr_addr, wr_ptr_gray, full, wr_count, almost_full
   );

   modport slave (
      input  wr_req, rd_ptr_gray,
      output wr_en, wr_addr, wr_ptr_gray, full, wr_count, almost_full
   );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl : write-domain pointer/flag controller of an async FIFO.
//   Keeps a binary write pointer, exports it in Gray code, synchronises the
//   read Gray pointer with two flops and derives registered full, fill level
//   and (optionally) almost-full flags.
// Ports:
//   wr_clk    write clock, rising edge
//   wr_rst_n  asynchronous active-low reset
//   bus       fifo_wr_ctrl_if.slave (see interface file for signals)
// Parameters:
//   ADDR_WIDTH          address width, depth = 2**ADDR_WIDTH
//   ALMOST_FULL_THRESH  free-entry count at/below which almost_full asserts
// Build option:
//   FIFO_WR_ALMOST_FULL_EN  when defined, almost_full logic is built;
//                           otherwise almost_full is tied to 0.
// ---------------------------------------------------------------------------
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH         = 6,
   parameter int ALMOST_FULL_THRESH = 4
) (
   input  logic             wr_clk,
   input  logic             wr_rst_n,
   fifo_wr_ctrl_if.slave    bus
);
   localparam int AW = ADDR_WIDTH;

   logic [AW:0] r_wbin;
   logic [AW:0] r_rq1;
   logic [AW:0] r_rq2;
   logic [AW:0] r_wptr_gray;
   logic [AW:0] r_count;
   logic        r_full;

   logic        w_wr_go;
   logic [AW:0] w_wbin_next;
   logic [AW:0] w_gray_next;
   logic [AW:0] w_full_match;
   logic [AW:0] w_rq2_bin;
   logic [AW:0] w_count_next;
   logic        w_full_next;

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Gate with reset so the strobe is quiet while reset is held.
   assign w_wr_go      = bus.wr_req & ~r_full & wr_rst_n;
   assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wr_go};
   assign w_gray_next  = (w_wbin_next >> 1) ^ w_wbin_next;
   // Writer is one full lap ahead of the reader: top two Gray bits differ.
   assign w_full_match = {~r_rq2[AW:AW-1], r_rq2[AW-2:0]};
   assign w_full_next  = (w_gray_next == w_full_match);
   assign w_rq2_bin    = gray2bin(r_rq2);
   assign w_count_next = w_wbin_next - w_rq2_bin;

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_wbin      <= '0;
         r_rq1       <= '0;
         r_rq2       <= '0;
         r_wptr_gray <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
      end else begin
         r_rq1       <= bus.rd_ptr_gray;
         r_rq2       <= r_rq1;
         r_wbin      <= w_wbin_next;
         r_wptr_gray <= w_gray_next;
         r_count     <= w_count_next;
         r_full      <= w_full_next;
      end
   end

   assign bus.wr_en       = w_wr_go;
   assign bus.wr_addr     = r_wbin[AW-1:0];
   assign bus.wr_ptr_gray = r_wptr_gray;
   assign bus.full        = r_full;
   assign bus.wr_count    = r_count;

`ifdef FIFO_WR_ALMOST_FULL_EN
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(1) << AW;
   localparam logic [AW:0] THRESH_W = (AW+1)'(ALMOST_FULL_THRESH);

   logic        r_almost_full;
   logic [AW:0] w_free_next;

   // wr_count never exceeds the depth, so this cannot wrap.
   assign w_free_next = DEPTH_W - w_count_next;

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_free_next <= THRESH_W);
      end
   end

   assign bus.almost_full = r_almost_full;
`else
   assign bus.almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ctrl : directed testbench for fifo_wr_ctrl (ADDR_WIDTH=6,
// ALMOST_FULL_THRESH=4). Inputs change 1 ns after a rising edge; outputs
// are sampled at that point too.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ctrl;
   localparam int AW = 6;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fifo_wr_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_THRESH(4)) dut (
      .wr_clk   (clk),
      .wr_rst_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.wr_req = 1'b1;
      bus.rd_ptr_gray = '0;
      #3;
      tick();
      n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %0h exp 0", bus.wr_en); end
      n_vec++; if (bus.wr_addr !== 6'd0) begin n_err++; $display("FAIL reset_wr_addr got %0h exp 0", bus.wr_addr); end
      n_vec++; if (bus.wr_ptr_gray !== 7'd0) begin n_err++; $display("FAIL reset_wr_ptr_gray got %0h exp 0", bus.wr_ptr_gray); end
      n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0h exp 0", bus.full); end
      n_vec++; if (bus.wr_count !== 7'd0) begin n_err++; $display("FAIL reset_wr_count got %0h exp 0", bus.wr_count); end
      n_vec++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full got %0h exp 0", bus.almost_full); end
      bus.wr_req = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      logic exp_af;
      bus.wr_req = 1'b1;
      #1;
      n_vec++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL fill_first_wr_en got %0h exp 1", bus.wr_en); end
      for (int i = 1; i <= 64; i++) begin
         tick();
         n_vec++; if (bus.wr_count !== 7'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.wr_count, i); end
         n_vec++; if (bus.full !== (i == 64)) begin n_err++; $display("FAIL fill_full[%0d] got %0h exp %0h", i, bus.full, (i == 64)); end
`ifdef FIFO_WR_ALMOST_FULL_EN
         exp_af = (i >= 60);
`else
         exp_af = 1'b0;
`endif
         n_vec++; if (bus.almost_full !== exp_af) begin n_err++; $display("FAIL fill_almost_full[%0d] got %0h exp %0h", i, bus.almost_full, exp_af); end
      end
      n_vec++; if (bus.wr_addr !== 6'd0) begin n_err++; $display("FAIL fill_wr_addr got %0h exp 0", bus.wr_addr); end
      n_vec++; if (bus.wr_ptr_gray !== 7'b1100000) begin n_err++; $display("FAIL fill_wr_ptr_gray got %b exp 1100000", bus.wr_ptr_gray); end
   endtask

   task automatic test_write_while_full();
      bus.wr_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL wwf_wr_en[%0d] got %0h exp 0", i, bus.wr_en); end
         tick();
         n_vec++; if (bus.wr_addr !== 6'd0) begin n_err++; $display("FAIL wwf_wr_addr[%0d] got %0h exp 0", i, bus.wr_addr); end
         n_vec++; if (bus.wr_count !== 7'd64) begin n_err++; $display("FAIL wwf_wr_count[%0d] got %0d exp 64", i, bus.wr_count); end
         n_vec++; if (bus.wr_ptr_gray !== 7'b1100000) begin n_err++; $display("FAIL wwf_wr_ptr_gray[%0d] got %b exp 1100000", i, bus.wr_ptr_gray); end
         n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL wwf_full[%0d] got %0h exp 1", i, bus.full); end
      end
   endtask

   task automatic test_release();
      logic exp_full [3];
      exp_full = '{1'b1, 1'b1, 1'b0};
      bus.wr_req = 1'b0;
      bus.rd_ptr_gray = 7'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (bus.full !== exp_full[i]) begin n_err++; $display("FAIL release_full[edge %0d] got %0h exp %0h", i + 1, bus.full, exp_full[i]); end
      end
      n_vec++; if (bus.wr_count !== 7'd63) begin n_err++; $display("FAIL release_wr_count got %0d exp 63", bus.wr_count); end
      bus.wr_req = 1'b1;
      #1;
      n_vec++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL release_wr_en got %0h exp 1", bus.wr_en); end
      n_vec++; if (bus.wr_addr !== 6'd0) begin n_err++; $display("FAIL release_wr_addr got %0h exp 0", bus.wr_addr); end
      tick();
      bus.wr_req = 1'b0;
      n_vec++; if (bus.wr_addr !== 6'd1) begin n_err++; $display("FAIL release_next_addr got %0h exp 1", bus.wr_addr); end
      n_vec++; if (bus.wr_count !== 7'd64) begin n_err++; $display("FAIL release_refill_count got %0d exp 64", bus.wr_count); end
      n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL release_refill_full got %0h exp 1", bus.full); end
      n_vec++; if (bus.wr_ptr_gray !== 7'b1100001) begin n_err++; $display("FAIL release_refill_gray got %b exp 1100001", bus.wr_ptr_gray); end
   endtask

   task automatic test_reset_mid_burst();
      bus.wr_req = 1'b0;
      bus.rd_ptr_gray = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      bus.wr_req = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      n_vec++; if (bus.wr_addr !== 6'd10) begin n_err++; $display("FAIL burst_wr_addr got %0d exp 10", bus.wr_addr); end
      n_vec++; if (bus.wr_count !== 7'd10) begin n_err++; $display("FAIL burst_wr_count got %0d exp 10", bus.wr_count); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.wr_addr !== 6'd0) begin n_err++; $display("FAIL midrst_wr_addr got %0d exp 0", bus.wr_addr); end
      n_vec++; if (bus.wr_count !== 7'd0) begin n_err++; $display("FAIL midrst_wr_count got %0d exp 0", bus.wr_count); end
      n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en got %0h exp 0", bus.wr_en); end
      n_vec++; if (bus.wr_ptr_gray !== 7'd0) begin n_err++; $display("FAIL midrst_wr_ptr_gray got %0h exp 0", bus.wr_ptr_gray); end
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      n_vec++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL resume_wr_en got %0h exp 1", bus.wr_en); end
      n_vec++; if (bus.wr_addr !== 6'd0) begin n_err++; $display("FAIL resume_wr_addr got %0d exp 0", bus.wr_addr); end
      tick();
      n_vec++; if (bus.wr_addr !== 6'd1) begin n_err++; $display("FAIL resume_next_addr got %0d exp 1", bus.wr_addr); end
      n_vec++; if (bus.wr_count !== 7'd1) begin n_err++; $display("FAIL resume_wr_count got %0d exp 1", bus.wr_count); end
      n_vec++; if (bus.wr_ptr_gray !== 7'd1) begin n_err++; $display("FAIL resume_wr_ptr_gray got %0h exp 1", bus.wr_ptr_gray); end
      bus.wr_req = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_fill();
      test_write_while_full();
      test_release();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
